// File: rtl/traffic_lanes_pkg.sv
// rtl/traffic_lanes_pkg.sv - shared Frog screen constants, traffic FSM encoding and wrap helper
//
// Holds the display/box geometry that the traffic parameters default to,
// the RESET/RUN/FROZEN state encoding, and the modular distance helper used
// by the per-lane hit test.

package traffic_lanes_pkg;

    localparam int H_DISPLAY_DEF     = 640;
    localparam int V_DISPLAY_DEF     = 480;
    localparam int LANE_TOP_DEF      = 320;
    localparam int LANE_PITCH_DEF    = 32;
    localparam int CAR_WIDTH_DEF     = 32;
    localparam int CAR_HEIGHT_DEF    = 32;
    localparam int PLAYER_WIDTH_DEF  = 32;
    localparam int PLAYER_HEIGHT_DEF = 32;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    // (a - b) mod m, for a and b both already in 0..m-1.
    function automatic logic [10:0] wrap_dist(input logic [10:0] a,
                                              input logic [10:0] b,
                                              input logic [10:0] m);
        return (a >= b) ? (a - b) : (a + m - b);
    endfunction

endpackage

// File: rtl/traffic_lane.sv
// rtl/traffic_lane.sv - one traffic lane: frame counter, wrapping car x register and hit test
//
// Optional feature macro: TRAFFIC_LEVEL_EN (step scaled by level when defined).
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   advance          qualified frame tick (RUN state, no collision this cycle)
//   level[1:0]       speed level, step << level when TRAFFIC_LEVEL_EN is defined
//   h_count, v_count beam position
//   hit              combinational: beam is on this lane's car (visible area only)

module traffic_lane
    import traffic_lanes_pkg::*;
#(
    parameter int         H_DISPLAY  = H_DISPLAY_DEF,
    parameter int         V_DISPLAY  = V_DISPLAY_DEF,
    parameter int         CAR_WIDTH  = CAR_WIDTH_DEF,
    parameter int         CAR_HEIGHT = CAR_HEIGHT_DEF,
    parameter int         Y_TOP      = LANE_TOP_DEF,
    parameter logic [9:0] X0         = 10'd0,
    parameter logic [5:0] STEP       = 6'd1,
    parameter logic       DIR        = 1'b1,
    parameter logic [3:0] PERIOD     = 4'd1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       advance,
    input  logic [1:0] level,
    input  logic [9:0] h_count,
    input  logic [9:0] v_count,
    output logic       hit
);

    localparam logic [10:0] H11      = 11'(H_DISPLAY);
    localparam logic [10:0] V11      = 11'(V_DISPLAY);
    localparam logic [10:0] CW11     = 11'(CAR_WIDTH);
    localparam logic [10:0] Y_LO     = 11'(Y_TOP);
    localparam logic [10:0] Y_HI     = 11'(Y_TOP + CAR_HEIGHT);
    // A period of 0 behaves as 1: move on every qualified tick.
    localparam logic [3:0]  PER_LAST = (PERIOD == 4'd0) ? 4'd0 : PERIOD - 4'd1;

    logic [9:0]  x;
    logic [3:0]  frame_cnt;
    logic [7:0]  step_eff;
    logic [10:0] x11;
    logic [10:0] s11;
    logic [10:0] sum;
    logic [10:0] nx;
    logic [10:0] h11;
    logic [10:0] v11;
    logic [10:0] dx;

`ifdef TRAFFIC_LEVEL_EN
    assign step_eff = {2'b00, STEP} << level;
`else
    logic level_unused;
    assign level_unused = ^level;
    assign step_eff     = {2'b00, STEP};
`endif

    assign x11 = {1'b0, x};
    assign s11 = {3'b000, step_eff};
    assign sum = x11 + s11;

    always_comb begin
        nx = x11;
        if (DIR) begin
            nx = (sum >= H11) ? (sum - H11) : sum;
        end else begin
            nx = (x11 < s11) ? (x11 + H11 - s11) : (x11 - s11);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x         <= X0;
            frame_cnt <= 4'd0;
        end else if (advance) begin
            if (frame_cnt >= PER_LAST) begin
                frame_cnt <= 4'd0;
                x         <= nx[9:0];
            end else begin
                frame_cnt <= frame_cnt + 4'd1;
            end
        end
    end

    // Modular distance lets a car straddling the right edge also draw from column 0.
    assign h11 = {1'b0, h_count};
    assign v11 = {1'b0, v_count};
    assign dx  = wrap_dist(h11, x11, H11);
    assign hit = (h11 < H11) && (v11 < V11) &&
                 (dx < CW11) && (v11 >= Y_LO) && (v11 < Y_HI);

endmodule

// File: rtl/traffic_lanes.sv
// rtl/traffic_lanes.sv - Frog traffic engine: lanes, car mask, lane index and sticky collision FSM
//
// Optional feature macro: TRAFFIC_LEVEL_EN (speed level scaling of lane steps).
// Ports:
//   CLK, RST_N          pixel clock, synchronous active-low reset
//   i_frame_tick        one pulse per frame, in vertical blank
//   h_count, v_count    beam position
//   player_x, player_y  player box top-left corner
//   i_clear             clears collision flag, resumes motion from FROZEN
//   i_level[1:0]        speed level
//   o_car_pixel         registered: beam on any car
//   o_lane_idx[2:0]     registered: lowest lane index under beam (0 if none)
//   o_collision         sticky player/car overlap
//   o_hit_lane[2:0]     lane of first overlap since last clear
//   o_running           state is RUN

module traffic_lanes
    import traffic_lanes_pkg::*;
#(
    parameter int                       NUM_LANES     = 4,
    parameter int                       H_DISPLAY     = H_DISPLAY_DEF,
    parameter int                       V_DISPLAY     = V_DISPLAY_DEF,
    parameter int                       LANE_TOP      = LANE_TOP_DEF,
    parameter int                       LANE_PITCH    = LANE_PITCH_DEF,
    parameter int                       CAR_WIDTH     = CAR_WIDTH_DEF,
    parameter int                       CAR_HEIGHT    = CAR_HEIGHT_DEF,
    parameter int                       PLAYER_WIDTH  = PLAYER_WIDTH_DEF,
    parameter int                       PLAYER_HEIGHT = PLAYER_HEIGHT_DEF,
    parameter logic [NUM_LANES*10-1:0]  LANE_X0       = '0,
    parameter logic [NUM_LANES*6-1:0]   LANE_STEP     = {NUM_LANES{6'd4}},
    parameter logic [NUM_LANES-1:0]     LANE_DIR      = '1,
    parameter logic [NUM_LANES*4-1:0]   LANE_PERIOD   = {NUM_LANES{4'd1}}
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       i_frame_tick,
    input  logic [9:0] h_count,
    input  logic [9:0] v_count,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    input  logic       i_clear,
    input  logic [1:0] i_level,
    output logic       o_car_pixel,
    output logic [2:0] o_lane_idx,
    output logic       o_collision,
    output logic [2:0] o_hit_lane,
    output logic       o_running
);

    localparam logic [10:0] H11  = 11'(H_DISPLAY);
    localparam logic [10:0] V11  = 11'(V_DISPLAY);
    localparam logic [10:0] PW11 = 11'(PLAYER_WIDTH);
    localparam logic [10:0] PH11 = 11'(PLAYER_HEIGHT);

    state_t                 state;
    state_t                 state_next;
    logic [NUM_LANES-1:0]   hits;
    logic                   car_any;
    logic [2:0]             lane_enc;
    logic                   visible;
    logic                   player_hit;
    logic                   coll_set;
    logic                   advance;
    logic [10:0]            h11;
    logic [10:0]            v11;
    logic [10:0]            px11;
    logic [10:0]            py11;

    // A tick that lands on the collision edge must not move the cars.
    assign advance = i_frame_tick && (state == ST_RUN) && !coll_set;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        traffic_lane #(
            .H_DISPLAY  (H_DISPLAY),
            .V_DISPLAY  (V_DISPLAY),
            .CAR_WIDTH  (CAR_WIDTH),
            .CAR_HEIGHT (CAR_HEIGHT),
            .Y_TOP      (LANE_TOP + k * LANE_PITCH),
            .X0         (LANE_X0[k*10 +: 10]),
            .STEP       (LANE_STEP[k*6 +: 6]),
            .DIR        (LANE_DIR[k]),
            .PERIOD     (LANE_PERIOD[k*4 +: 4])
        ) u_lane (
            .clk     (CLK),
            .rst_n   (RST_N),
            .advance (advance),
            .level   (i_level),
            .h_count (h_count),
            .v_count (v_count),
            .hit     (hits[k])
        );
    end

    assign car_any = |hits;

    // Lowest lane index wins where lanes overlap.
    always_comb begin
        lane_enc = 3'd0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (hits[i]) lane_enc = 3'(i);
        end
    end

    assign h11        = {1'b0, h_count};
    assign v11        = {1'b0, v_count};
    assign px11       = {1'b0, player_x};
    assign py11       = {1'b0, player_y};
    assign visible    = (h11 < H11) && (v11 < V11);
    assign player_hit = (h11 >= px11) && (h11 < px11 + PW11) &&
                        (v11 >= py11) && (v11 < py11 + PH11);

    // Clear has priority over a simultaneous overlap.
    assign coll_set = car_any && player_hit && visible &&
                      !o_collision && !i_clear && (state == ST_RUN);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= ST_RESET;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RESET:  state_next = ST_RUN;
            ST_RUN:    if (coll_set) state_next = ST_FROZEN;
            ST_FROZEN: if (i_clear)  state_next = ST_RUN;
            default:   state_next = ST_RESET;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            o_car_pixel <= 1'b0;
            o_lane_idx  <= 3'd0;
            o_collision <= 1'b0;
            o_hit_lane  <= 3'd0;
        end else begin
            o_car_pixel <= car_any;
            o_lane_idx  <= car_any ? lane_enc : 3'd0;
            if (i_clear) begin
                o_collision <= 1'b0;
            end else if (coll_set) begin
                o_collision <= 1'b1;
                o_hit_lane  <= lane_enc;
            end
        end
    end

    assign o_running = (state == ST_RUN);

endmodule

// File: tb/tb_traffic_lanes.sv
// tb/tb_traffic_lanes.sv - directed self-checking bench for traffic_lanes

module tb_traffic_lanes;

`ifdef TRAFFIC_LEVEL_EN
    localparam int LVL_MUL = 4;
`else
    localparam int LVL_MUL = 1;
`endif

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       i_frame_tick;
    logic [9:0] h_count;
    logic [9:0] v_count;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic       i_clear;
    logic [1:0] i_level;
    logic       o_car_pixel;
    logic [2:0] o_lane_idx;
    logic       o_collision;
    logic [2:0] o_hit_lane;
    logic       o_running;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    // lane0 x=200 +20 right p1; lane1 x=5 -20 left p1; lane2 x=630 +20 right p2; lane3 x=400 +5 right p0
    traffic_lanes #(
        .NUM_LANES   (4),
        .LANE_X0     ({10'd400, 10'd630, 10'd5, 10'd200}),
        .LANE_STEP   ({6'd5, 6'd20, 6'd20, 6'd20}),
        .LANE_DIR    (4'b1101),
        .LANE_PERIOD ({4'd0, 4'd2, 4'd1, 4'd1})
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .i_frame_tick (i_frame_tick),
        .h_count      (h_count),
        .v_count      (v_count),
        .player_x     (player_x),
        .player_y     (player_y),
        .i_clear      (i_clear),
        .i_level      (i_level),
        .o_car_pixel  (o_car_pixel),
        .o_lane_idx   (o_lane_idx),
        .o_collision  (o_collision),
        .o_hit_lane   (o_hit_lane),
        .o_running    (o_running)
    );

    task automatic step_cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic blank();
        h_count = 10'd700;
        v_count = 10'd500;
    endtask

    task automatic probe(input string tag, input int h, input int v,
                         input logic exp_pix, input logic [2:0] exp_idx);
        h_count = 10'(h);
        v_count = 10'(v);
        step_cyc();
        chk({tag, "_pix"}, 32'(o_car_pixel), 32'(exp_pix));
        chk({tag, "_idx"}, 32'(o_lane_idx), 32'(exp_idx));
        blank();
    endtask

    task automatic tick();
        blank();
        i_frame_tick = 1'b1;
        step_cyc();
        i_frame_tick = 1'b0;
    endtask

    initial begin
        RST_N = 1'b0; i_frame_tick = 1'b0; i_clear = 1'b0; i_level = 2'd0;
        player_x = 10'd0; player_y = 10'd0;
        h_count = 10'd200; v_count = 10'd320;
        repeat (3) step_cyc();
        chk("rst_running",   32'(o_running),   32'd0);
        chk("rst_car_pixel", 32'(o_car_pixel), 32'd0);
        chk("rst_lane_idx",  32'(o_lane_idx),  32'd0);
        chk("rst_collision", 32'(o_collision), 32'd0);
        chk("rst_hit_lane",  32'(o_hit_lane),  32'd0);

        RST_N = 1'b1;
        blank();
        step_cyc();
        chk("release_running", 32'(o_running), 32'd1);

        probe("l0_x200",     200, 320, 1'b1, 3'd0);
        probe("l0_x199",     199, 320, 1'b0, 3'd0);
        probe("l1_x5",         5, 352, 1'b1, 3'd1);
        probe("l1_x4",         4, 352, 1'b0, 3'd0);
        probe("l2_h639",     639, 384, 1'b1, 3'd2);
        probe("l2_h0",         0, 384, 1'b1, 3'd2);
        probe("l2_h21",       21, 384, 1'b1, 3'd2);
        probe("l2_h22",       22, 384, 1'b0, 3'd0);
        probe("l2_hblank",   640, 384, 1'b0, 3'd0);
        probe("l3_x400",     400, 416, 1'b1, 3'd3);

        tick();
        probe("t1_l0_220",   220, 320, 1'b1, 3'd0);
        probe("t1_l0_219",   219, 320, 1'b0, 3'd0);
        probe("t1_l1_625",   625, 352, 1'b1, 3'd1);
        probe("t1_l1_624",   624, 352, 1'b0, 3'd0);
        probe("t1_l2_hold",  630, 384, 1'b1, 3'd2);
        probe("t1_l3_405",   405, 416, 1'b1, 3'd3);
        probe("t1_l3_404",   404, 416, 1'b0, 3'd0);

        tick();
        probe("t2_l2_10",     10, 384, 1'b1, 3'd2);
        probe("t2_l2_9",       9, 384, 1'b0, 3'd0);
        probe("t2_l2_639",   639, 384, 1'b0, 3'd0);
        probe("t2_l0_240",   240, 320, 1'b1, 3'd0);

        RST_N = 1'b0;
        step_cyc();
        chk("midrst_running", 32'(o_running), 32'd0);
        RST_N = 1'b1;
        step_cyc();
        probe("midrst_l0_200", 200, 320, 1'b1, 3'd0);
        probe("midrst_l0_240", 240, 320, 1'b0, 3'd0);

        player_x = 10'd200; player_y = 10'd320;
        h_count = 10'd200; v_count = 10'd320;
        i_frame_tick = 1'b1;
        step_cyc();
        i_frame_tick = 1'b0;
        blank();
        chk("coll_set",      32'(o_collision), 32'd1);
        chk("coll_hit_lane", 32'(o_hit_lane),  32'd0);
        chk("coll_running",  32'(o_running),   32'd0);
        tick();
        tick();
        player_x = 10'd0; player_y = 10'd0;
        probe("frozen_l0_200", 200, 320, 1'b1, 3'd0);
        probe("frozen_l0_199", 199, 320, 1'b0, 3'd0);
        probe("frozen_l3_400", 400, 416, 1'b1, 3'd3);
        chk("frozen_sticky", 32'(o_collision), 32'd1);

        i_clear = 1'b1;
        step_cyc();
        i_clear = 1'b0;
        chk("clear_coll",    32'(o_collision), 32'd0);
        chk("clear_running", 32'(o_running),   32'd1);
        tick();
        probe("resume_l0_220", 220, 320, 1'b1, 3'd0);
        probe("resume_l0_219", 219, 320, 1'b0, 3'd0);
        probe("resume_l3_405", 405, 416, 1'b1, 3'd3);

        player_x = 10'd220; player_y = 10'd320;
        h_count = 10'd220; v_count = 10'd320;
        i_clear = 1'b1;
        step_cyc();
        i_clear = 1'b0;
        chk("clrwin_coll",    32'(o_collision), 32'd0);
        chk("clrwin_running", 32'(o_running),   32'd1);
        player_x = 10'd405; player_y = 10'd416;
        h_count = 10'd405; v_count = 10'd416;
        step_cyc();
        chk("reset_coll",    32'(o_collision), 32'd1);
        chk("reset_hitlane", 32'(o_hit_lane),  32'd3);
        chk("reset_running", 32'(o_running),   32'd0);
        player_x = 10'd220; player_y = 10'd320;
        h_count = 10'd220; v_count = 10'd320;
        step_cyc();
        chk("first_hit_kept", 32'(o_hit_lane), 32'd3);
        blank();
        player_x = 10'd0; player_y = 10'd0;
        i_clear = 1'b1;
        step_cyc();
        i_clear = 1'b0;
        chk("clear2_coll", 32'(o_collision), 32'd0);

        i_level = 2'd2;
        tick();
        i_level = 2'd0;
        probe("lvl_l3_at",  405 + 5 * LVL_MUL,     416, 1'b1, 3'd3);
        probe("lvl_l3_bef", 405 + 5 * LVL_MUL - 1, 416, 1'b0, 3'd0);
        probe("lvl_l0_at",  220 + 20 * LVL_MUL,    320, 1'b1, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
